// File: rtl/sh_wdt_if.sv
// Peripheral-bus register port of the SH-2 watchdog timer (FFFFFE80-FFFFFE83).
interface sh_wdt_if;
  logic [1:0]  REG_A;
  logic [15:0] REG_DI;
  logic        REG_WE;
  logic        REG_RD;
  logic        REG_SEL;
  logic [7:0]  REG_DO;

  modport master (output REG_A, REG_DI, REG_WE, REG_RD, REG_SEL, input REG_DO);
  modport slave  (input REG_A, REG_DI, REG_WE, REG_RD, REG_SEL, output REG_DO);
endinterface

// File: rtl/sh_wdt.sv
// SH-2 watchdog timer: WTCSR/WTCNT/RSTCSR, phi prescaler, interval IRQ and
// watchdog overflow pulse with optional internal reset request.
module sh_wdt #(
  parameter int OVF_PULSE = 128
) (
  input  logic     CLK,
  input  logic     RST_N,
  input  logic     CE_R,
  sh_wdt_if.slave  bus,
  output logic     ITI,
  output logic     WDTOVF_N,
  output logic     RES_REQ,
  output logic     RES_TYPE
);
  localparam int PW = $clog2(OVF_PULSE + 1);
  localparam logic [PW-1:0] PLAST = PW'(OVF_PULSE - 1);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_PULSE = 1'b1;

  logic        ovf_q, ovf_d, wtit_q, wtit_d, tme_q, tme_d;
  logic [2:0]  cks_q, cks_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wovf_q, wovf_d, rste_q, rste_d, rsts_q, rsts_d;
  logic [12:0] pre_q, pre_d;
  logic [0:0]  st_q, st_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic        res_en_q, res_en_d, rtype_q, rtype_d;

  logic       tick, wr, wr_cnt, wr_csr, wr_wclr, wr_rst, inc, ovf_ev;
  logic [7:0] key;

  always_comb begin
    case (cks_q)
      3'd0:    tick = pre_q[0];
      3'd1:    tick = &pre_q[5:0];
      3'd2:    tick = &pre_q[6:0];
      3'd3:    tick = &pre_q[7:0];
      3'd4:    tick = &pre_q[8:0];
      3'd5:    tick = &pre_q[9:0];
      3'd6:    tick = &pre_q[11:0];
      default: tick = &pre_q[12:0];
    endcase
  end

  // Keyed writes: upper byte is the protection key, anything else is dropped.
  assign key     = bus.REG_DI[15:8];
  assign wr      = bus.REG_SEL & bus.REG_WE & CE_R;
  assign wr_cnt  = wr & (bus.REG_A == 2'd0) & (key == 8'h5A);
  assign wr_csr  = wr & (bus.REG_A == 2'd0) & (key == 8'hA5);
  assign wr_wclr = wr & (bus.REG_A == 2'd2) & (key == 8'hA5) & (bus.REG_DI[7:0] == 8'h00);
  assign wr_rst  = wr & (bus.REG_A == 2'd2) & (key == 8'h5A);
  // A counter write in the tick cycle suppresses both increment and overflow.
  assign inc     = CE_R & tme_q & tick & ~wr_cnt;
  assign ovf_ev  = inc & (cnt_q == 8'hFF);

  always_comb begin
    ovf_d = ovf_q; wtit_d = wtit_q; tme_d = tme_q; cks_d = cks_q;
    cnt_d = cnt_q; wovf_d = wovf_q; rste_d = rste_q; rsts_d = rsts_q;
    pre_d = pre_q; st_d = st_q; pcnt_d = pcnt_q;
    res_en_d = res_en_q; rtype_d = rtype_q;
    if (CE_R) begin
      pre_d = pre_q + 13'd1;
      if (wr_csr && !bus.REG_DI[5]) pre_d = '0;
      if (wr_cnt)   cnt_d = bus.REG_DI[7:0];
      else if (inc) cnt_d = cnt_q + 8'd1;
      if (wr_csr) begin
        wtit_d = bus.REG_DI[6];
        tme_d  = bus.REG_DI[5];
        cks_d  = bus.REG_DI[2:0];
        if (!bus.REG_DI[7]) ovf_d = 1'b0;
      end
      if (ovf_ev && !wtit_q) ovf_d = 1'b1;
      if (wr_wclr) wovf_d = 1'b0;
      if (ovf_ev && wtit_q) wovf_d = 1'b1;
      if (wr_rst) begin
        rste_d = bus.REG_DI[6];
        rsts_d = bus.REG_DI[5];
      end
      case (st_q)
        ST_IDLE: if (ovf_ev && wtit_q) begin
          st_d     = ST_PULSE;
          pcnt_d   = '0;
          res_en_d = rste_q;
          rtype_d  = rsts_q;
        end
        default: begin
          if (pcnt_q == PLAST) st_d = ST_IDLE;
          else                 pcnt_d = pcnt_q + PW'(1);
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovf_q <= 1'b0; wtit_q <= 1'b0; tme_q <= 1'b0; cks_q <= '0;
      cnt_q <= '0; wovf_q <= 1'b0; rste_q <= 1'b0; rsts_q <= 1'b0;
      pre_q <= '0; st_q <= ST_IDLE; pcnt_q <= '0;
      res_en_q <= 1'b0; rtype_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d; wtit_q <= wtit_d; tme_q <= tme_d; cks_q <= cks_d;
      cnt_q <= cnt_d; wovf_q <= wovf_d; rste_q <= rste_d; rsts_q <= rsts_d;
      pre_q <= pre_d; st_q <= st_d; pcnt_q <= pcnt_d;
      res_en_q <= res_en_d; rtype_q <= rtype_d;
    end
  end

  always_comb begin
    bus.REG_DO = 8'h00;
    if (bus.REG_SEL) begin
      case (bus.REG_A)
        2'd0:    bus.REG_DO = {ovf_q, wtit_q, tme_q, 2'b11, cks_q};
        2'd1:    bus.REG_DO = cnt_q;
        2'd2:    bus.REG_DO = 8'hFF;
        default: bus.REG_DO = {wovf_q, rste_q, rsts_q, 5'h1F};
      endcase
    end
  end

  assign ITI      = ovf_q & ~wtit_q & tme_q;
  assign WDTOVF_N = ~(st_q == ST_PULSE);
  assign RES_REQ  = (st_q == ST_PULSE) & res_en_q;
  assign RES_TYPE = rtype_q;
endmodule

// File: tb/tb_sh_wdt.sv
// Bench for sh_wdt: behavioural register-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sh_wdt;
  localparam int OVF_PULSE = 128;

  logic CLK = 1'b0, RST_N = 1'b0, CE_R = 1'b1;
  logic ITI, WDTOVF_N, RES_REQ, RES_TYPE;
  sh_wdt_if bus();

  sh_wdt #(.OVF_PULSE(OVF_PULSE)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .bus(bus.slave),
    .ITI(ITI), .WDTOVF_N(WDTOVF_N), .RES_REQ(RES_REQ), .RES_TYPE(RES_TYPE)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_ovf = 0, m_wtit = 0, m_tme = 0, m_cks = 0, m_cnt = 0;
  int m_wovf = 0, m_rste = 0, m_rsts = 0, m_pre = 0;
  int m_left = 0, m_res = 0, m_rtype = 0;
  int kdiv[8] = '{1, 6, 7, 8, 9, 10, 12, 13};

  task automatic m_reset();
    m_ovf = 0; m_wtit = 0; m_tme = 0; m_cks = 0; m_cnt = 0;
    m_wovf = 0; m_rste = 0; m_rsts = 0; m_pre = 0;
    m_left = 0; m_res = 0; m_rtype = 0;
  endtask

  task automatic m_step();
    int n_ovf, n_wtit, n_tme, n_cks, n_cnt, n_wovf, n_rste, n_rsts, n_pre, n_left, n_res, n_rtype;
    int a, key, lo;
    bit we, tick, cw, inc, ev;
    a = int'(bus.REG_A); key = int'(bus.REG_DI[15:8]); lo = int'(bus.REG_DI[7:0]);
    we = bus.REG_SEL && bus.REG_WE;
    tick = ((m_pre + 1) % (1 << kdiv[m_cks])) == 0;
    cw = we && a == 0 && key == 'h5A;
    inc = m_tme != 0 && tick && !cw;
    ev = inc && m_cnt == 255;
    n_ovf = m_ovf; n_wtit = m_wtit; n_tme = m_tme; n_cks = m_cks; n_wovf = m_wovf;
    n_rste = m_rste; n_rsts = m_rsts; n_res = m_res; n_rtype = m_rtype;
    n_cnt = cw ? lo : (inc ? (m_cnt + 1) % 256 : m_cnt);
    n_pre = (m_pre + 1) % 8192;
    if (we && a == 0 && key == 'hA5) begin
      n_wtit = (lo >> 6) & 1; n_tme = (lo >> 5) & 1; n_cks = lo & 7;
      if (((lo >> 7) & 1) == 0) n_ovf = 0;
      if (n_tme == 0) n_pre = 0;
    end
    if (ev && m_wtit == 0) n_ovf = 1;
    if (we && a == 2 && key == 'hA5 && lo == 0) n_wovf = 0;
    if (ev && m_wtit != 0) n_wovf = 1;
    if (we && a == 2 && key == 'h5A) begin
      n_rste = (lo >> 6) & 1; n_rsts = (lo >> 5) & 1;
    end
    n_left = (m_left > 0) ? m_left - 1 : 0;
    if (m_left == 0 && ev && m_wtit != 0) begin
      n_left = OVF_PULSE; n_res = m_rste; n_rtype = m_rsts;
    end
    m_ovf = n_ovf; m_wtit = n_wtit; m_tme = n_tme; m_cks = n_cks; m_cnt = n_cnt;
    m_wovf = n_wovf; m_rste = n_rste; m_rsts = n_rsts; m_pre = n_pre;
    m_left = n_left; m_res = n_res; m_rtype = n_rtype;
  endtask

  function automatic logic [11:0] m_out();
    int rd;
    rd = 0;
    if (bus.REG_SEL)
      case (int'(bus.REG_A))
        0: rd = m_ovf * 128 + m_wtit * 64 + m_tme * 32 + 'h18 + m_cks;
        1: rd = m_cnt;
        2: rd = 'hFF;
        default: rd = m_wovf * 128 + m_rste * 64 + m_rsts * 32 + 'h1F;
      endcase
    return {8'(rd), 1'(m_ovf & ~m_wtit & m_tme), 1'(m_left == 0),
            1'(m_left > 0 && m_res != 0), 1'(m_rtype)};
  endfunction

  initial forever begin
    @(posedge CLK or negedge RST_N);
    if (!RST_N) m_reset();
    else if (CE_R) m_step();
  end

  initial forever begin
    @(negedge CLK);
    chk("outputs_vs_model", {20'd0, bus.REG_DO, ITI, WDTOVF_N, RES_REQ, RES_TYPE}, {20'd0, m_out()});
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    bus.REG_SEL = 1'b1; bus.REG_WE = 1'b1; bus.REG_A = a; bus.REG_DI = d;
    @(posedge CLK); #1;
    bus.REG_SEL = 1'b0; bus.REG_WE = 1'b0;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [7:0] exp, input string nm);
    bus.REG_SEL = 1'b1; bus.REG_RD = 1'b1; bus.REG_A = a;
    @(negedge CLK);
    chk(nm, {24'd0, bus.REG_DO}, {24'd0, exp});
    @(posedge CLK); #1;
    bus.REG_SEL = 1'b0; bus.REG_RD = 1'b0;
  endtask

  task automatic wait_pin_low(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge CLK);
      if (WDTOVF_N === 1'b0) found = 1'b1;
    end
    chk("wdtovf_seen", {31'd0, found}, 32'd1);
  endtask

  initial begin
    bit found;
    int lowc, resc;
    bus.REG_A = '0; bus.REG_DI = '0; bus.REG_WE = 1'b0; bus.REG_RD = 1'b0; bus.REG_SEL = 1'b0;

    // reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_pins", {28'd0, bus.REG_DO[0], ITI, WDTOVF_N, RES_REQ}, {28'd0, 4'b0010});
    chk("rst_do_unsel", {24'd0, bus.REG_DO}, 32'h00);
    @(posedge CLK); #1;
    rd_chk(2'd0, 8'h18, "rst_wtcsr");
    rd_chk(2'd3, 8'h1F, "rst_rstcsr");
    RST_N = 1'b1;

    // write protection
    wr(2'd0, 16'h1234);
    rd_chk(2'd0, 8'h18, "wp_wtcsr");
    rd_chk(2'd1, 8'h00, "wp_wtcnt");
    rd_chk(2'd2, 8'hFF, "rd_a2");
    wr(2'd0, 16'h5A80);
    rd_chk(2'd1, 8'h80, "wtcnt_wr");

    // interval mode, phi/2
    wr(2'd0, 16'hA500);
    wr(2'd0, 16'h5AFE);
    wr(2'd0, 16'hA520);
    idle(3);
    rd_chk(2'd1, 8'hFF, "int_cnt_ff");
    rd_chk(2'd1, 8'h00, "int_cnt_wrap");
    chk("int_iti", {31'd0, ITI}, 32'd1);
    rd_chk(2'd0, 8'hB8, "int_wtcsr_ovf");
    wr(2'd0, 16'hA5A0);
    rd_chk(2'd0, 8'hB8, "ovf_kept_di7");
    wr(2'd0, 16'hA520);
    rd_chk(2'd0, 8'h38, "ovf_cleared");
    chk("iti_cleared", {31'd0, ITI}, 32'd0);

    // collision: write in the overflow tick cycle wins
    wr(2'd0, 16'hA500);
    wr(2'd0, 16'h5AFF);
    wr(2'd0, 16'hA520);
    idle(1);
    wr(2'd0, 16'h5A10);
    rd_chk(2'd1, 8'h10, "coll_cnt");
    chk("coll_iti", {31'd0, ITI}, 32'd0);
    rd_chk(2'd0, 8'h38, "coll_ovf");

    // prescaler CKS=7: tick 8192 cycles after the clearing write
    wr(2'd0, 16'hA507);
    wr(2'd0, 16'h5A00);
    wr(2'd0, 16'hA527);
    idle(8189);
    rd_chk(2'd1, 8'h00, "cks7_before");
    rd_chk(2'd1, 8'h01, "cks7_after");

    // prescaler CKS=3: every 256 cycles
    wr(2'd0, 16'hA503);
    wr(2'd0, 16'hA523);
    idle(254);
    rd_chk(2'd1, 8'h01, "cks3_t1_before");
    rd_chk(2'd1, 8'h02, "cks3_t1_after");
    idle(254);
    rd_chk(2'd1, 8'h02, "cks3_t2_before");
    rd_chk(2'd1, 8'h03, "cks3_t2_after");
    wr(2'd0, 16'hA500);

    // watchdog overflow pulse with reset request
    wr(2'd2, 16'h5A60);
    wr(2'd0, 16'h5AFF);
    wr(2'd0, 16'hA560);
    wait_pin_low(found);
    chk("wd_res_type", {31'd0, RES_TYPE}, 32'd1);
    lowc = 0; resc = 0;
    if (found) begin
      lowc = 1; resc = (RES_REQ === 1'b1) ? 1 : 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge CLK);
        if (WDTOVF_N !== 1'b0) break;
        lowc++;
        if (RES_REQ === 1'b1) resc++;
      end
    end
    chk("wd_pulse_len", lowc, OVF_PULSE);
    chk("wd_resreq_len", resc, OVF_PULSE);
    @(posedge CLK); #1;
    rd_chk(2'd3, 8'hFF, "wd_rstcsr");
    wr(2'd2, 16'hA500);
    rd_chk(2'd3, 8'h7F, "wd_wovf_clr");
    wr(2'd0, 16'hA500);

    // asynchronous reset in the middle of a pulse
    wr(2'd0, 16'h5AFF);
    wr(2'd0, 16'hA560);
    wait_pin_low(found);
    repeat (60) @(negedge CLK);
    #1 RST_N = 1'b0;
    #1;
    chk("arst_pins", {30'd0, WDTOVF_N, RES_REQ}, {30'd0, 2'b10});
    @(posedge CLK); #1;
    rd_chk(2'd0, 8'h18, "arst_wtcsr");
    rd_chk(2'd1, 8'h00, "arst_wtcnt");
    rd_chk(2'd3, 8'h1F, "arst_rstcsr");
    chk("arst_rtype", {31'd0, RES_TYPE}, 32'd0);
    RST_N = 1'b1;
    lowc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (WDTOVF_N !== 1'b1) lowc++;
    end
    chk("no_pulse_after_rst", lowc, 0);
    @(posedge CLK); #1;

    // CE_R gating: writes without CE_R are ignored
    wr(2'd0, 16'h5A33);
    CE_R = 1'b0;
    wr(2'd0, 16'h5A77);
    rd_chk(2'd1, 8'h33, "ce_wr_ignored");
    CE_R = 1'b1;
    rd_chk(2'd1, 8'h33, "ce_wr_ignored2");

    // random CE_R with mixed writes, checked by the model
    wr(2'd0, 16'h5AF0);
    wr(2'd0, 16'hA520);
    for (int i = 0; i < 400; i++) begin
      CE_R = 1'($urandom_range(0, 3) != 0);
      if (i % 29 == 0) begin
        bus.REG_SEL = 1'b1; bus.REG_WE = 1'b1;
        case ($urandom_range(0, 4))
          0: begin bus.REG_A = 2'd0; bus.REG_DI = {8'h5A, 8'($urandom_range(240, 255))}; end
          1: begin bus.REG_A = 2'd0; bus.REG_DI = 16'hA5A0; end
          2: begin bus.REG_A = 2'd0; bus.REG_DI = 16'hA520; end
          3: begin bus.REG_A = 2'd2; bus.REG_DI = 16'h5A40; end
          default: begin bus.REG_A = 2'd1; bus.REG_DI = 16'h5A00; end
        endcase
      end else begin
        bus.REG_SEL = 1'($urandom_range(0, 1)); bus.REG_WE = 1'b0;
        bus.REG_A = 2'($urandom_range(0, 3));
      end
      @(posedge CLK); #1;
    end
    CE_R = 1'b1; bus.REG_SEL = 1'b0; bus.REG_WE = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sh_wdt.md
Name: sh_wdt

Overview:
- SH-2 on-chip watchdog timer: the peripheral stage behind the WTCSR/WTCNT/RSTCSR register definitions.
- Accepts peripheral-bus register accesses at FFFFFE80–FFFFFE83 and runs an 8-bit up-counter from a φ prescaler.
- Interval mode: drives the level interrupt request ITI to the INTC.
- Watchdog mode: drives the external WDTOVF_N pulse and an internal reset request to the reset controller.

Parameters:
- OVF_PULSE, 128, length of the WDTOVF_N / RES_REQ pulse in CE_R cycles.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset; asynchronous, active-low.
- CE_R  in  1  φ rising-edge enable; all state advances only when CE_R=1.
- REG_A  in  2  byte offset from FFFFFE80.
- REG_DI  in  16  write data (word writes only).
- REG_WE  in  1  write strobe, qualified by CE_R and REG_SEL.
- REG_RD  in  1  read strobe.
- REG_SEL  in  1  address decode hit for FFFFFE80–FFFFFE83.
- REG_DO  out  8  read data, combinational from REG_A.
- ITI  out  1  interval-timer interrupt request (level).
- WDTOVF_N  out  1  external overflow pin, active-low.
- RES_REQ  out  1  internal reset request.
- RES_TYPE  out  1  reset type: 0 = power-on, 1 = manual (copy of RSTS).

Behaviour:
- Reset values:
  - WTCSR: OVF=0, WTIT=0, TME=0, CKS=0; reads as 0x18 (unused bits read 1).
  - WTCNT=0x00.
  - RSTCSR: WOVF=0, RSTE=0, RSTS=0; reads as 0x1F.
  - Prescaler=0.
  - Outputs: ITI=0, WDTOVF_N=1, RES_REQ=0, RES_TYPE=0, REG_DO=0x00 when not selected.
- Writes (REG_SEL & REG_WE & CE_R), keyed on REG_A and REG_DI[15:8]:
  - A=0, key 0x5A: WTCNT <= DI[7:0].
  - A=0, key 0xA5: WTIT, TME, CKS <= DI[6], DI[5], DI[2:0]. OVF is cleared only if DI[7]=0; DI[7]=1 leaves OVF unchanged.
  - A=2, key 0xA5 with DI[7:0]=0x00: WOVF <= 0.
  - A=2, key 0x5A: RSTE, RSTS <= DI[6], DI[5].
  - Any other key/offset combination is ignored (write protection).
- Reads (byte):
  - A=0: WTCSR | 0x18.
  - A=1: WTCNT.
  - A=3: RSTCSR | 0x1F.
  - A=2: 0xFF.
  - Reads have no side effects.
- Prescaler:
  - 13-bit free-running counter, increments every CE_R.
  - Tick occurs when the low k bits are all ones, with k = {1,6,7,8,9,10,12,13} for CKS = 0..7, i.e. φ/2, /64, /128, /256, /512, /1024, /4096, /8192.
  - Clearing TME (write 0) also clears the prescaler.
- Counter: when TME=1 and tick, WTCNT <= WTCNT+1, wrapping 0xFF→0x00. Overflow is the 0xFF→0x00 transition.
- Overflow, WTIT=0 (interval mode): OVF <= 1; TME stays 1 and counting continues.
- Overflow, WTIT=1 (watchdog mode):
  - WOVF <= 1, then pulse state machine IDLE→PULSE.
  - WDTOVF_N=0 for OVF_PULSE CE_R cycles, starting the cycle after overflow.
  - If RSTE=1, RES_REQ=1 for the same window and RES_TYPE=RSTS latched at overflow.
  - Counting continues during the pulse.
  - Overflow during PULSE sets WOVF but does not restart the pulse.
  - PULSE→IDLE when the pulse count reaches OVF_PULSE.
- ITI = OVF & ~WTIT & TME.
- Simultaneous events:
  - WTCNT write in the same cycle as a tick: the write wins; no increment, no overflow.
  - OVF clear write in the same cycle as an overflow: OVF ends at 1 (the set wins).
  - WOVF clear in the same cycle as a watchdog overflow: WOVF ends at 1.
- Reset asserted at any time, including mid-pulse: all state returns to reset values immediately (asynchronous).
- Latency: register writes are visible on REG_DO the next CE_R cycle; ITI asserts the cycle after the overflow.

Test Plan:
- Write-protect:
  - Write 0x1234 to A=0 → WTCSR reads 0x18, WTCNT reads 0x00.
  - Write 0x5A80 to A=0 → WTCNT reads 0x80.
- Interval mode:
  - Write 0x5AFE to A=0, then 0xA520 (TME=1, CKS=0).
  - Required: WTCNT reaches 0x00 after 4 CE_R cycles; OVF=1; ITI=1; WTCSR reads 0xB8.
  - Then write 0xA520 → ITI=0 and OVF=0 with counting continuing.
- Prescaler select:
  - CKS=7, TME=1, WTCNT=0: WTCNT=1 after 8192 CE_R cycles and exactly 0 one cycle earlier.
  - CKS=3: increments every 256 CE_R cycles.
- Watchdog reset:
  - Write 0x5A60 to A=2 (RSTE=1, RSTS=1), 0x5AFF to A=0, then 0xA560 to A=0.
  - Required: on overflow, WDTOVF_N=0 and RES_REQ=1 for exactly 128 cycles; RES_TYPE=1; RSTCSR reads 0xFF.
  - Then write 0xA500 to A=2 → RSTCSR reads 0x7F.
- Collision: WTCNT=0xFF, tick and write 0x5A10 in the same cycle → WTCNT=0x10, OVF stays 0, ITI stays 0.
- Reset mid-pulse: drive RST_N low 60 cycles into a watchdog pulse → WDTOVF_N=1, RES_REQ=0, all registers at reset values; no pulse after RST_N is released.
